// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, LSB-first assembly,
// one-cycle data_valid / framing_err pulses and a registered busy flag.
module uart_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_err,
    output logic       busy
);
    localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      r_state;
    logic [1:0]  r_sync;
    logic [15:0] r_clk_count;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_rx;

    assign w_rx = r_sync[1];

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], rx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_clk_count <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_count <= '0;
                    if (!w_rx) begin
                        r_state <= START;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (r_clk_count == HALF_LAST) begin
                        r_clk_count <= '0;
                        if (!w_rx) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 16'd1;
                    end
                end
                DATA: begin
                    if (r_clk_count == BIT_LAST) begin
                        r_clk_count          <= '0;
                        r_shift[r_bit_idx]   <= w_rx;
                        if (r_bit_idx == 3'd7) r_state   <= STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_clk_count <= r_clk_count + 16'd1;
                    end
                end
                STOP: begin
                    if (r_clk_count == BIT_LAST) begin
                        r_clk_count <= '0;
                        if (w_rx) begin
                            data_out   <= r_shift;
                            data_valid <= 1'b1;
                            r_state    <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            framing_err <= 1'b1;
                            r_state     <= WAIT_IDLE;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low break stays here so it yields a single error.
                    r_clk_count <= '0;
                    if (w_rx) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed cases plus random frames scored against an event queue.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    uart_rx #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
        .clk(clk), .reset(reset), .rx(rx), .data_out(data_out),
        .data_valid(data_valid), .framing_err(framing_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] b;
        int         t;
    } exp_t;

    // Pulse lands 2 (sync) + 1 (t0) + 8 + 9*16 cycles after the start bit is driven.
    localparam int LAT = 2 + 1 + 8 + 9 * 16;

    exp_t       exp_q[$];
    exp_t       e;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_vld = 0;
    int         n_fe = 0;
    int         last_vld_cyc = 0;
    int         prev_vld_cyc = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_busy = 1'b0;
    logic       prev_dv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid || framing_err) begin
            chk("exclusive", 32'(data_valid & framing_err), 0);
            chk("dv_width", 32'(prev_dv & data_valid), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 32'(framing_err), 32'(e.err));
                chk("pulse_latency", 32'(cyc - e.t), LAT);
                if (data_valid) begin
                    chk("data", 32'(data_out), 32'(e.b));
                    chk("busy_fall", 32'(busy), 0);
                    chk("busy_before", 32'(prev_busy), 1);
                    last_good    = e.b;
                    prev_vld_cyc = last_vld_cyc;
                    last_vld_cyc = cyc;
                    n_vld++;
                end else begin
                    chk("fe_hold", 32'(data_out), 32'(last_good));
                    n_fe++;
                end
            end
        end
        prev_busy = busy;
        prev_dv   = data_valid;
    end

    // Called on a negedge; returns on the negedge where the next bit would start.
    task automatic send(input logic [7:0] b, input logic stop, input bit expect_evt,
                        input int abort_idx);
        logic [9:0] bits;
        exp_t       x;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 0 && expect_evt) begin
                x.err = ~stop; x.b = b; x.t = cyc;
                exp_q.push_back(x);
            end
            if (i == abort_idx) begin
                repeat (8) @(negedge clk);
                reset = 1'b0;
                last_good = 8'h00;
                @(negedge clk);
                chk("midreset_data", 32'(data_out), 0);
                chk("midreset_busy", 32'(busy), 0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
                rx = 1'b1;
                return;
            end
            repeat (16) @(negedge clk);
        end
    endtask

    initial begin
        int d, nv, nf, hold, gap;
        logic [7:0] b;
        logic bad;

        rx = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_fe", 32'(framing_err), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_data", 32'(data_out), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_pulses", 32'(n_vld + n_fe), 0);

        nv = n_vld;
        send(8'h5A, 1'b1, 1'b1, -1);
        repeat (20) @(negedge clk);
        chk("single_count", 32'(n_vld - nv), 1);
        chk("single_data", 32'(data_out), 32'h5A);

        nv = n_vld;
        send(8'h00, 1'b1, 1'b1, -1);
        send(8'hFF, 1'b1, 1'b1, -1);
        repeat (20) @(negedge clk);
        chk("b2b_count", 32'(n_vld - nv), 2);
        chk("b2b_spacing", 32'(last_vld_cyc - prev_vld_cyc), 160);
        chk("b2b_data", 32'(data_out), 32'hFF);

        nv = n_vld; nf = n_fe;
        rx = 1'b0; d = cyc;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        chk("glitch_busy_hi", 32'(busy), 1);
        repeat (7) @(negedge clk);
        chk("glitch_busy_lo", 32'(cyc - d), 11);
        chk("glitch_busy_lo", 32'(busy), 0);
        repeat (30) @(negedge clk);
        chk("glitch_pulses", 32'((n_vld - nv) + (n_fe - nf)), 0);
        chk("glitch_data", 32'(data_out), 32'hFF);

        nv = n_vld; nf = n_fe;
        send(8'hA5, 1'b0, 1'b1, -1);
        repeat (100) @(negedge clk);
        chk("break_busy", 32'(busy), 1);
        chk("break_fe", 32'(n_fe - nf), 1);
        chk("break_dv", 32'(n_vld - nv), 0);
        chk("break_data", 32'(data_out), 32'hFF);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_lo", 32'(busy), 0);

        nv = n_vld; nf = n_fe;
        send(8'h3C, 1'b1, 1'b0, 4);
        repeat (40) @(negedge clk);
        chk("abort_pulses", 32'((n_vld - nv) + (n_fe - nf)), 0);
        chk("abort_data", 32'(data_out), 0);
        send(8'hC3, 1'b1, 1'b1, -1);
        repeat (20) @(negedge clk);
        chk("abort_next_count", 32'(n_vld - nv), 1);
        chk("abort_next_data", 32'(data_out), 32'hC3);

        for (int k = 0; k < 24; k++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send(b, ~bad, 1'b1, -1);
            if (bad) begin
                hold = $urandom_range(0, 40);
                repeat (hold) @(negedge clk);
                rx  = 1'b1;
                gap = $urandom_range(2, 10);
            end else begin
                gap = $urandom_range(0, 12);
            end
            repeat (gap) @(negedge clk);
        end
        repeat (200) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 0);
        chk("final_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
